// File: rtl/dibu_pkg.sv
// dibu_pkg: shared register-bank constants, read/write encodings and bank command struct
package dibu_pkg;
  localparam int REG_AW = 3;
  localparam int REG_DW = 8;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  typedef struct packed {
    logic              rw;
    logic [REG_AW-1:0] ri_a;
    logic [REG_AW-1:0] ri_b;
    logic [REG_AW-1:0] ri_d;
    logic [REG_DW-1:0] d;
  } bank_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; scans from ptr_i, grants first set req_i bit
//   req_i : N-wide request vector
//   ptr_i : index of highest-priority requester this cycle
//   gnt_o : one-hot grant, all-zero when nothing requests
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic          found;
  logic [PW-1:0] idx;
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin sharing of the 1W/2R register bank between NREQ requesters
//   clk, rst             : clock, synchronous active-high reset
//   req_*                : per-requester valid/we/indices/data, req_ready one-hot grant
//   rsp_valid/rsp_a/rsp_b: tagged read response, two cycles after accept
//   bank_*               : command to the bank and its registered read data
//   REGBANK_ARB_LOCK_EN  : adds req_lock, letting a requester hold exclusive ownership
module regbank_arbiter import dibu_pkg::*; #(
  parameter int NREQ = 2,
  parameter int DW   = REG_DW,
  parameter int AW   = REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_ra,
  input  logic [NREQ*AW-1:0] req_rb,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_d,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_a,
  output logic [DW-1:0]      rsp_b,
  output logic               bank_rw,
  output logic [AW-1:0]      bank_ri_a,
  output logic [AW-1:0]      bank_ri_b,
  output logic [AW-1:0]      bank_ri_d,
  output logic [DW-1:0]      bank_d,
  input  logic [DW-1:0]      bank_a,
  input  logic [DW-1:0]      bank_b
);
  localparam int PW = $clog2(NREQ);
  bank_cmd_t       cmd_q, cmd_d;
  logic            rd_q, rd_d, rd2_q;
  logic [PW-1:0]   tag_q, tag2_q, ptr_q, ptr_d, gidx;
  logic [NREQ-1:0] req_eff, gnt;
  logic            any_gnt, locked;
`ifdef REGBANK_ARB_LOCK_EN
  logic            lock_q;
  logic [PW-1:0]   owner_q;
  assign locked  = lock_q;
  assign req_eff = lock_q ? (req_valid & (NREQ'(1) << owner_q)) : req_valid;
  always_ff @(posedge clk)
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (any_gnt) begin
      lock_q  <= req_lock[gidx];
      owner_q <= gidx;
    end
`else
  assign locked  = 1'b0;
  assign req_eff = req_valid;
`endif
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );
  assign req_ready = rst ? '0 : gnt;
  assign any_gnt   = |req_ready;
  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt[k]) gidx = PW'(k);
  end
  // Idle cycles issue a dummy read with indices held, so the bank sees no write.
  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.rw = RW_READ;
    if (any_gnt) begin
      cmd_d.rw   = req_we[gidx];
      cmd_d.ri_a = req_ra[gidx*AW +: AW];
      cmd_d.ri_b = req_rb[gidx*AW +: AW];
      cmd_d.ri_d = req_rd[gidx*AW +: AW];
      cmd_d.d    = req_d[gidx*DW +: DW];
    end
  end
  assign rd_d  = any_gnt & ~req_we[gidx];
  assign ptr_d = (any_gnt && !locked) ? PW'((int'(gidx) + 1) % NREQ) : ptr_q;
  always_ff @(posedge clk)
    if (rst) begin
      cmd_q  <= '0;
      rd_q   <= 1'b0;
      tag_q  <= '0;
      rd2_q  <= 1'b0;
      tag2_q <= '0;
      ptr_q  <= '0;
    end else begin
      cmd_q  <= cmd_d;
      rd_q   <= rd_d;
      tag_q  <= gidx;
      rd2_q  <= rd_q;
      tag2_q <= tag_q;
      ptr_q  <= ptr_d;
    end
  assign bank_rw   = cmd_q.rw;
  assign bank_ri_a = cmd_q.ri_a;
  assign bank_ri_b = cmd_q.ri_b;
  assign bank_ri_d = cmd_q.ri_d;
  assign bank_d    = cmd_q.d;
  assign rsp_valid = rd2_q ? (NREQ'(1) << tag2_q) : '0;
  assign rsp_a     = bank_a;
  assign rsp_b     = bank_b;
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed checks of regbank_arbiter against a behavioural 8x8 bank
module tb_regbank_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [5:0]  req_ra, req_rb, req_rd;
  logic [15:0] req_d;
`ifdef REGBANK_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif
  logic [7:0]  rsp_a, rsp_b, bank_d, bank_a, bank_b;
  logic        bank_rw;
  logic [2:0]  bank_ri_a, bank_ri_b, bank_ri_d;
  logic [7:0]  mem [8];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  regbank_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd), .req_d(req_d),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .bank_rw(bank_rw), .bank_ri_a(bank_ri_a), .bank_ri_b(bank_ri_b),
    .bank_ri_d(bank_ri_d), .bank_d(bank_d), .bank_a(bank_a), .bank_b(bank_b)
  );
  always @(posedge clk) begin
    if (bank_rw) mem[bank_ri_d] <= bank_d;
    bank_a <= mem[bank_ri_a];
    bank_b <= mem[bank_ri_b];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; req_valid = 2'b11; req_we = '0;
    req_ra = '0; req_rb = '0; req_rd = '0; req_d = '0;
`ifdef REGBANK_ARB_LOCK_EN
    req_lock = '0;
`endif
    @(negedge clk); check("rst_ready_c0", 32'(req_ready), 0);
    @(negedge clk); check("rst_ready_c1", 32'(req_ready), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_rw", 32'(bank_rw), 0);
    step(); rst = 1'b0;
    @(negedge clk); check("first_grant", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00;
    step(); step();
    step(); req_valid = 2'b01; req_we = 2'b01; req_rd[2:0] = 3'd3; req_d[7:0] = 8'h5A;
    @(negedge clk); check("wr_r3_ready", 32'(req_ready), 32'b01);
    step(); req_rd[2:0] = 3'd4; req_d[7:0] = 8'hC3;
    @(negedge clk); check("wr_r4_ready", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00; req_we = 2'b00;
    step(); req_valid = 2'b01; req_ra[2:0] = 3'd3; req_rb[2:0] = 3'd4;
    @(negedge clk); check("rd_ready", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00;
    @(negedge clk); check("rd_n1_rsp", 32'(rsp_valid), 0);
    step();
    @(negedge clk); check("rd_n2_rsp", 32'(rsp_valid), 32'b01);
    check("rd_a", 32'(rsp_a), 32'h5A);
    check("rd_b", 32'(rsp_b), 32'hC3);
    step();
    @(negedge clk); check("rd_n3_rsp", 32'(rsp_valid), 0);
    step(); req_valid = 2'b10; req_we = 2'b10; req_rd[5:3] = 3'd2; req_d[15:8] = 8'h77;
    @(negedge clk); check("wtr_wr_ready", 32'(req_ready), 32'b10);
    step(); req_valid = 2'b01; req_we = 2'b00; req_ra[2:0] = 3'd2; req_rb[2:0] = 3'd2;
    @(negedge clk); check("wtr_rd_ready", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00;
    @(negedge clk); check("wtr_n2_rsp", 32'(rsp_valid), 0);
    step();
    @(negedge clk); check("wtr_n3_rsp", 32'(rsp_valid), 32'b01);
    check("wtr_a", 32'(rsp_a), 32'h77);
    check("wtr_b", 32'(rsp_b), 32'h77);
    step(); req_valid = 2'b10; req_ra[5:3] = 3'd2; req_rb[5:3] = 3'd3;
    @(negedge clk); check("r1_ready", 32'(req_ready), 32'b10);
    step(); req_valid = 2'b00;
    step();
    @(negedge clk); check("r1_rsp", 32'(rsp_valid), 32'b10);
    check("r1_a", 32'(rsp_a), 32'h77);
    check("r1_b", 32'(rsp_b), 32'h5A);
    req_ra = {3'd4, 3'd3}; req_rb = {3'd4, 3'd3};
    for (int k = 0; k < 7; k++) begin
      step(); req_valid = (k < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (k < 4) check($sformatf("cont_ready%0d", k), 32'(req_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
      if (k >= 2 && k < 6) begin
        check($sformatf("cont_rsp%0d", k), 32'(rsp_valid), (k % 2 == 1) ? 32'b10 : 32'b01);
        check($sformatf("cont_a%0d", k), 32'(rsp_a), (k % 2 == 1) ? 32'hC3 : 32'h5A);
      end
      if (k == 6) check("cont_drain", 32'(rsp_valid), 0);
    end
    step(); req_valid = 2'b01;
    @(negedge clk); check("mid_ready", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00; rst = 1'b1;
    @(negedge clk); check("mid_rst_ready", 32'(req_ready), 0);
    step(); rst = 1'b0;
    @(negedge clk); check("mid_rsp", 32'(rsp_valid), 0);
    check("mid_rw", 32'(bank_rw), 0);
    check("mid_ri_a", 32'(bank_ri_a), 0);
    check("mid_ri_b", 32'(bank_ri_b), 0);
    check("mid_ri_d", 32'(bank_ri_d), 0);
    check("mid_d", 32'(bank_d), 0);
    step(); req_valid = 2'b11;
    @(negedge clk); check("mid_ptr", 32'(req_ready), 32'b01);
    step(); req_valid = 2'b00;
`ifdef REGBANK_ARB_LOCK_EN
    step(); req_valid = 2'b01; req_lock = 2'b01;
    @(negedge clk); check("lock_take", 32'(req_ready), 32'b01);
    for (int k = 0; k < 3; k++) begin
      step(); req_valid = 2'b11;
      @(negedge clk); check($sformatf("lock_hold%0d", k), 32'(req_ready), 32'b01);
    end
    step(); req_lock = 2'b00;
    @(negedge clk); check("lock_release", 32'(req_ready), 32'b01);
    step();
    @(negedge clk); check("lock_after", 32'(req_ready), 32'b10);
    step(); req_valid = 2'b00;
`endif
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
